rr_arbiter_4: RTL and testbench

Four-requester round-robin arbiter that shares one downstream resource, such as the priority-encoded datapath, among four clients. It takes a request vector, grants exactly one owner at a time, and holds the grant until the owner signals done, drops its request, or exceeds a hold limit. The grant is reported both as a one-hot vector and as a 3-bit code in the `{valid, index[1:0]}` format the 4-to-2 priority encoder produces.

---
 rtl/rr_arbiter_4_pkg.sv | 22 ++
 rtl/rr_arbiter_4_pick4.sv | 34 +++
 rtl/rr_arbiter_4.sv | 129 ++++++++++++
 tb/tb_rr_arbiter_4.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter_4_pkg.sv
// Shared definitions for the four-requester round-robin arbiter:
// FSM state encodings and the {valid, index} grant code format.
package rr_arbiter_4_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // Grant code is {valid, idx[1:0]}, matching the 4-to-2 priority encoder.
    localparam int         CODE_VLD_BIT = 2;
    localparam logic [2:0] CODE_NONE    = 3'b000;

    function automatic logic [2:0] make_code(input logic [1:0] idx);
        logic [2:0] code;
        code               = {1'b0, idx};
        code[CODE_VLD_BIT] = 1'b1;
        return code;
    endfunction

endpackage

// File: rtl/rr_arbiter_4_pick4.sv
// Combinational round-robin pick: rotate the request vector so the pointer
// position sits at bit 0, take the lowest set bit, then rotate the index back.
module rr_pick4
    import rr_arbiter_4_pkg::*;
(
    input  logic [3:0] i_req,
    input  logic [1:0] i_ptr,
    output logic [3:0] o_pick,
    output logic [2:0] o_code
);

    logic [7:0] req_dbl;
    logic [3:0] req_rot;
    logic [1:0] rot_idx;
    logic       rot_vld;
    logic [1:0] idx;

    // Rotate, fixed-priority encode (lowest index wins), un-rotate.
    always_comb begin
        req_dbl = {i_req, i_req};
        req_rot = req_dbl[i_ptr +: 4];
        rot_vld = |req_rot;
        rot_idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) begin
                rot_idx = 2'(k);
            end
        end
        idx    = rot_idx + i_ptr;
        o_pick = rot_vld ? (4'b0001 << idx) : 4'b0000;
        o_code = rot_vld ? make_code(idx) : CODE_NONE;
    end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter. Holds a grant until the owner signals
// done, drops its request, or reaches the hold limit; one dead cycle separates
// successive owners. All outputs come straight from flops.
module rr_arbiter_4
    import rr_arbiter_4_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [3:0] o_gnt,
    output logic [2:0] o_gnt_code,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_SAT = '1;
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    state_e            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [2:0]        code_q, code_d;
    logic              busy_q, busy_d;
    logic              timeout_q, timeout_d;

    logic [3:0]        pick_gnt;
    logic [2:0]        pick_code;
    logic [1:0]        owner_idx;
    logic              owner_req;
    logic              hold_hit;
    logic              release_now;
    logic              any_req;

    rr_pick4 u_pick (
        .i_req  (i_req),
        .i_ptr  (ptr_q),
        .o_pick (pick_gnt),
        .o_code (pick_code)
    );

    // Release conditions for the current owner, derived from registered state.
    always_comb begin
        any_req     = |i_req;
        owner_idx   = code_q[1:0];
        owner_req   = i_req[owner_idx];
        hold_hit    = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);
        release_now = i_done || !owner_req || hold_hit;
    end

    // State register plus pointer, hold counter and output registers.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= 2'd0;
            hold_q    <= '0;
            gnt_q     <= 4'b0000;
            code_q    <= CODE_NONE;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            gnt_q     <= gnt_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_req) state_d = ST_GRANT;
            ST_GRANT:   if (release_now) state_d = ST_RELEASE;
            ST_RELEASE: state_d = any_req ? ST_GRANT : ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        gnt_d     = gnt_q;
        code_d    = code_q;
        timeout_d = 1'b0;
        busy_d    = (state_d != ST_IDLE);
        case (state_q)
            ST_GRANT: begin
                if (release_now) begin
                    gnt_d     = 4'b0000;
                    code_d    = CODE_NONE;
                    hold_d    = '0;
                    ptr_d     = owner_idx + 2'd1;
                    // Only a pure hold-limit revoke is a timeout; done wins.
                    timeout_d = hold_hit && !i_done && owner_req;
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + HOLD_ONE;
                end
            end
            default: begin
                // IDLE and RELEASE both start a new grant from the current ptr.
                if (any_req) begin
                    gnt_d  = pick_gnt;
                    code_d = pick_code;
                    hold_d = HOLD_ONE;
                end else begin
                    gnt_d  = 4'b0000;
                    code_d = CODE_NONE;
                    hold_d = '0;
                end
            end
        endcase
    end

    assign o_gnt      = gnt_q;
    assign o_gnt_code = code_q;
    assign o_busy     = busy_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed bench for rr_arbiter_4 with MAX_HOLD=4.
module tb_rr_arbiter_4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [2:0] code;
    logic       busy;
    logic       tmo;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.MAX_HOLD(4), .HOLD_W(8)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_req      (req),
        .i_done     (done),
        .o_gnt      (gnt),
        .o_gnt_code (code),
        .o_busy     (busy),
        .o_timeout  (tmo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic outs(input string tag, input logic [3:0] e_gnt, input logic [2:0] e_code,
                        input logic e_busy, input logic e_to);
        chk({tag, "_gnt"},  32'(gnt),  32'(e_gnt));
        chk({tag, "_code"}, 32'(code), 32'(e_code));
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk({tag, "_tmo"},  32'(tmo),  32'(e_to));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    localparam logic [3:0] RR_GNT  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    localparam logic [2:0] RR_CODE [5] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b100};

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        done  = 1'b0;

        // Reset state
        step();
        step();
        outs("rst", 4'b0000, 3'b000, 1'b0, 1'b0);
        chk("rst_state", 32'(dut.state_q), 32'd0);
        chk("rst_ptr",   32'(dut.ptr_q),   32'd0);
        chk("rst_hold",  32'(dut.hold_q),  32'd0);
        rst_n = 1'b1;

        // No requests for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            outs("idle", 4'b0000, 3'b000, 1'b0, 1'b0);
            chk("idle_state", 32'(dut.state_q), 32'd0);
        end

        // 1010 from reset: client 1 then client 3
        do_reset();
        req = 4'b1010;
        step();
        outs("t2_g1", 4'b0010, 3'b101, 1'b1, 1'b0);
        done = 1'b1;
        step();
        outs("t2_rel", 4'b0000, 3'b000, 1'b1, 1'b0);
        chk("t2_ptr", 32'(dut.ptr_q), 32'd2);
        done = 1'b0;
        step();
        outs("t2_g3", 4'b1000, 3'b111, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        outs("t2_drop", 4'b0000, 3'b000, 1'b1, 1'b0);
        step();
        outs("t2_idle", 4'b0000, 3'b000, 1'b0, 1'b0);

        // All request, done on each grant's second cycle: 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            outs("t3_c1", RR_GNT[k], RR_CODE[k], 1'b1, 1'b0);
            step();
            outs("t3_c2", RR_GNT[k], RR_CODE[k], 1'b1, 1'b0);
            done = 1'b1;
            step();
            outs("t3_gap", 4'b0000, 3'b000, 1'b1, 1'b0);
            done = 1'b0;
        end
        req = 4'b0000;
        step();
        outs("t3_idle", 4'b0000, 3'b000, 1'b0, 1'b0);

        // Hold limit on client 2, re-grant, then back of the rotation
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 4; c++) begin
            step();
            outs("t4_hold", 4'b0100, 3'b110, 1'b1, 1'b0);
        end
        step();
        outs("t4_tmo", 4'b0000, 3'b000, 1'b1, 1'b1);
        chk("t4_ptr", 32'(dut.ptr_q), 32'd3);
        step();
        outs("t4_regnt", 4'b0100, 3'b110, 1'b1, 1'b0);
        req = 4'b0101;
        for (int c = 2; c <= 4; c++) begin
            step();
            outs("t4_hold2", 4'b0100, 3'b110, 1'b1, 1'b0);
        end
        step();
        outs("t4_tmo2", 4'b0000, 3'b000, 1'b1, 1'b1);
        step();
        outs("t4_next", 4'b0001, 3'b100, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        outs("t4_drop", 4'b0000, 3'b000, 1'b1, 1'b0);
        step();
        outs("t4_idle", 4'b0000, 3'b000, 1'b0, 1'b0);

        // Owner drops request mid-grant: 0001 -> 1000
        do_reset();
        req = 4'b0001;
        step();
        outs("t5_g0", 4'b0001, 3'b100, 1'b1, 1'b0);
        step();
        outs("t5_g0b", 4'b0001, 3'b100, 1'b1, 1'b0);
        req = 4'b1000;
        step();
        outs("t5_rel", 4'b0000, 3'b000, 1'b1, 1'b0);
        step();
        outs("t5_g3", 4'b1000, 3'b111, 1'b1, 1'b0);
        req = 4'b0000;
        step();
        step();
        outs("t5_idle", 4'b0000, 3'b000, 1'b0, 1'b0);

        // Reset during grant of client 2
        do_reset();
        req = 4'b0100;
        step();
        outs("t6_g2", 4'b0100, 3'b110, 1'b1, 1'b0);
        rst_n = 1'b0;
        step();
        outs("t6_rst", 4'b0000, 3'b000, 1'b0, 1'b0);
        chk("t6_ptr",   32'(dut.ptr_q),   32'd0);
        chk("t6_state", 32'(dut.state_q), 32'd0);
        rst_n = 1'b1;
        req   = 4'b1111;
        step();
        outs("t6_g0", 4'b0001, 3'b100, 1'b1, 1'b0);

        // Done coinciding with the hold limit: no timeout pulse
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 4; c++) begin
            step();
            outs("t7_hold", 4'b0010, 3'b101, 1'b1, 1'b0);
        end
        done = 1'b1;
        step();
        outs("t7_rel", 4'b0000, 3'b000, 1'b1, 1'b0);
        done = 1'b0;
        req  = 4'b0000;
        step();
        outs("t7_idle", 4'b0000, 3'b000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
